// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - two-pulse 8259 interrupt acknowledge engine with vector handoff
// Synchronizes INT, runs the INTA pulse train, captures the vector and offers it to the core.
module inta_sequencer #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_i,
    input  logic       ie,
    input  logic [7:0] d_i,
    output logic       inta_n,
    output logic [7:0] vec_o,
    output logic       vec_valid,
    input  logic       vec_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_GAP,
        S_P2,
        S_HOLD,
        S_RECOVER
    } state_t;

    localparam logic [CNT_W-1:0] LP_PULSE = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] LP_GAP   = CNT_W'(GAP_W);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [1:0]       r_sync;
    logic             r_inta_n;
    logic [7:0]       r_vec;
    logic             r_vec_valid;
    logic             w_int_s;
    logic             w_last;
    logic             w_capture;
    logic             w_consume;

    assign w_int_s = r_sync[1];
    assign w_last  = (r_cnt == LP_ONE);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_int_s && ie) begin
                    w_next_state = S_P1;
                    w_next_cnt   = LP_PULSE;
                end
            end
            S_P1: begin
                if (w_last) begin
                    w_next_state = S_GAP;
                    w_next_cnt   = LP_GAP;
                end else begin
                    w_next_cnt = r_cnt - LP_ONE;
                end
            end
            S_GAP: begin
                if (w_last) begin
                    w_next_state = S_P2;
                    w_next_cnt   = LP_PULSE;
                end else begin
                    w_next_cnt = r_cnt - LP_ONE;
                end
            end
            S_P2: begin
                // The PIC holds the vector on the bus until the end of the second pulse.
                if (w_last) begin
                    w_next_state = S_HOLD;
                    w_next_cnt   = '0;
                    w_capture    = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - LP_ONE;
                end
            end
            S_HOLD: begin
                if (r_vec_valid && vec_ready) begin
                    w_next_state = S_RECOVER;
                    w_next_cnt   = LP_GAP;
                    w_consume    = 1'b1;
                end
            end
            S_RECOVER: begin
                // Lets the synchronizer flush the serviced request before IDLE looks at it.
                if (w_last) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - LP_ONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sync      <= 2'b00;
            r_inta_n    <= 1'b1;
            r_vec       <= 8'h00;
            r_vec_valid <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], int_i};
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_inta_n <= !((w_next_state == S_P1) || (w_next_state == S_P2));
            if (w_capture) begin
                r_vec       <= d_i;
                r_vec_valid <= 1'b1;
            end else if (w_consume) begin
                r_vec_valid <= 1'b0;
            end
        end
    end

    assign inta_n    = r_inta_n;
    assign vec_o     = r_vec;
    assign vec_valid = r_vec_valid;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - self-checking bench for inta_sequencer
// A PIC model drives the vector on the second INTA pulse; a waveform model gives expected outputs.
module tb_inta_sequencer;

    localparam int P = 2;
    localparam int G = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       int_i     = 1'b0;
    logic       ie        = 1'b0;
    logic       vec_ready = 1'b0;
    logic [7:0] d_i       = 8'h00;
    logic       inta_n;
    logic [7:0] vec_o;
    logic       vec_valid;
    logic       busy;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         fall_cnt    = 0;
    logic       prev_inta   = 1'b1;
    logic [7:0] pic_vec     = 8'h00;

    always #5 clk = ~clk;

    inta_sequencer #(.PULSE_W(P), .GAP_W(G), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_i     (int_i),
        .ie        (ie),
        .d_i       (d_i),
        .inta_n    (inta_n),
        .vec_o     (vec_o),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .busy      (busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected {inta_n, vec_valid, busy} for sample k of a sequence whose first low sample is s
    // and whose first sample after the handshake edge is hs.
    function automatic logic [2:0] model_out(int k, int s, int hs);
        int   r;
        logic lo;
        r  = k - s;
        lo = (r >= 0 && r < P) || (r >= P + G && r < 2 * P + G);
        return {!lo, (k >= s + 2 * P + G) && (k < hs), (k >= s) && (k < hs + G)};
    endfunction

    // One clock; outputs sampled 1ns after the edge. The PIC drives its vector only during
    // every second low pulse, and junk that differs from the vector otherwise.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!inta_n && prev_inta) begin
            fall_cnt++;
            d_i = (fall_cnt % 2 == 0) ? pic_vec : (pic_vec ^ 8'($urandom_range(1, 255)));
        end else if (inta_n && !prev_inta) begin
            d_i = pic_vec ^ 8'($urandom_range(1, 255));
        end
        prev_inta = inta_n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ie = 1'b1;
        vec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int_i = 1'($urandom);
            step();
            vectors++;
            if ({inta_n, vec_valid, busy, vec_o} !== {3'b100, 8'h00}) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%b expected=%b", cyc,
                         {inta_n, vec_valid, busy, vec_o}, {3'b100, 8'h00});
            end
        end
        int_i = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if ({inta_n, vec_valid, busy} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_release_idle cyc=%0d got=%b expected=100", cyc,
                         {inta_n, vec_valid, busy});
            end
        end
    endtask

    task automatic test_basic();
        int         t, s, v, hs, last;
        logic [2:0] e;
        logic [7:0] vec;
        ie = 1'b1;
        vec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vec = (i == 0) ? 8'hAD : 8'($urandom);
            pic_vec = vec;
            repeat ($urandom_range(0, 4)) step();
            t = cyc;
            int_i = 1'b1;
            s = t + 3;
            v = s + 2 * P + G;
            hs = v + 1;
            last = hs + G + 3;
            while (cyc < last) begin
                if (cyc == s + P + G) int_i = 1'b0;
                step();
                e = model_out(cyc, s, hs);
                vectors++;
                if ({inta_n, vec_valid, busy} !== e) begin
                    miscompares++;
                    $display("FAIL basic_wave cyc=%0d got=%b expected=%b", cyc,
                             {inta_n, vec_valid, busy}, e);
                end
                if (cyc >= v) begin
                    vectors++;
                    if (vec_o !== vec) begin
                        miscompares++;
                        $display("FAIL basic_vec cyc=%0d got=%h expected=%h", cyc, vec_o, vec);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int         t, s, v, hs, last, d;
        logic [2:0] e;
        logic [7:0] vec;
        ie = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec = (i == 0) ? 8'hAD : 8'($urandom);
            d = (i == 0) ? 10 : int'($urandom_range(1, 12));
            pic_vec = vec;
            vec_ready = 1'b0;
            step();
            t = cyc;
            int_i = 1'b1;
            s = t + 3;
            v = s + 2 * P + G;
            hs = v + d + 1;
            last = hs + G + 3;
            while (cyc < last) begin
                if (cyc == s + P + G) int_i = 1'b0;
                if (cyc < v) vec_ready = 1'($urandom);
                else if (cyc < v + d) vec_ready = 1'b0;
                else vec_ready = 1'b1;
                step();
                e = model_out(cyc, s, hs);
                vectors++;
                if ({inta_n, vec_valid, busy} !== e) begin
                    miscompares++;
                    $display("FAIL backpressure_wave cyc=%0d got=%b expected=%b", cyc,
                             {inta_n, vec_valid, busy}, e);
                end
                if (cyc >= v) begin
                    vectors++;
                    if (vec_o !== vec) begin
                        miscompares++;
                        $display("FAIL backpressure_vec cyc=%0d got=%h expected=%h", cyc, vec_o, vec);
                    end
                end
            end
        end
        vec_ready = 1'b1;
    endtask

    task automatic test_gating();
        int         t, s, v, hs, last;
        logic [2:0] e;
        logic [7:0] vec;
        vec = 8'($urandom);
        pic_vec = vec;
        vec_ready = 1'b1;
        ie = 1'b0;
        int_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if ({inta_n, vec_valid, busy} !== 3'b100) begin
                miscompares++;
                $display("FAIL gating_ie_low cyc=%0d got=%b expected=100", cyc,
                         {inta_n, vec_valid, busy});
            end
        end
        t = cyc;
        ie = 1'b1;
        s = t + 1;
        v = s + 2 * P + G;
        hs = v + 1;
        last = hs + G + 3;
        while (cyc < last) begin
            if (cyc == s + P) ie = 1'b0;
            if (cyc == s + P + G) int_i = 1'b0;
            step();
            e = model_out(cyc, s, hs);
            vectors++;
            if ({inta_n, vec_valid, busy} !== e) begin
                miscompares++;
                $display("FAIL gating_wave cyc=%0d got=%b expected=%b", cyc,
                         {inta_n, vec_valid, busy}, e);
            end
            if (cyc == v) begin
                vectors++;
                if (vec_o !== vec) begin
                    miscompares++;
                    $display("FAIL gating_vec cyc=%0d got=%h expected=%h", cyc, vec_o, vec);
                end
            end
        end
        ie = 1'b1;
    endtask

    task automatic test_back_to_back();
        int         t, s1, v1, hs1, s2, v2, hs2, last, high_run, min_high;
        logic [2:0] e;
        ie = 1'b1;
        vec_ready = 1'b1;
        pic_vec = 8'h75;
        step();
        t = cyc;
        int_i = 1'b1;
        s1 = t + 3;
        v1 = s1 + 2 * P + G;
        hs1 = v1 + 1;
        s2 = hs1 + G + 1;
        v2 = s2 + 2 * P + G;
        hs2 = v2 + 1;
        last = hs2 + G + 3;
        high_run = 0;
        min_high = 1000;
        while (cyc < last) begin
            if (cyc == v1) pic_vec = 8'h76;
            if (cyc == s2 + P + G) int_i = 1'b0;
            step();
            e = (cyc < s2) ? model_out(cyc, s1, hs1) : model_out(cyc, s2, hs2);
            vectors++;
            if ({inta_n, vec_valid, busy} !== e) begin
                miscompares++;
                $display("FAIL b2b_wave cyc=%0d got=%b expected=%b", cyc,
                         {inta_n, vec_valid, busy}, e);
            end
            if (cyc > v1 - 1 && cyc <= s2) begin
                if (inta_n === 1'b1) high_run++;
                else if (high_run < min_high) min_high = high_run;
            end
            if (cyc == v1 || cyc == v2) begin
                vectors++;
                if (vec_o !== ((cyc == v1) ? 8'h75 : 8'h76)) begin
                    miscompares++;
                    $display("FAIL b2b_vec cyc=%0d got=%h expected=%h", cyc, vec_o,
                             (cyc == v1) ? 8'h75 : 8'h76);
                end
            end
        end
        vectors++;
        if (min_high < G) begin
            miscompares++;
            $display("FAIL b2b_gap got=%0d high cycles expected>=%0d", min_high, G);
        end
    endtask

    task automatic test_reset_mid_p2();
        int         t, s, v, hs, last;
        logic [2:0] e;
        logic [7:0] vec;
        ie = 1'b1;
        vec_ready = 1'b1;
        pic_vec = 8'($urandom);
        step();
        t = cyc;
        int_i = 1'b1;
        s = t + 3;
        while (cyc < s + P + G) step();
        vectors++;
        if (inta_n !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_p2_low cyc=%0d got=%b expected=0", cyc, inta_n);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({inta_n, vec_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL async_reset cyc=%0d got=%b expected=100", cyc, {inta_n, vec_valid, busy});
        end
        fall_cnt = 0;
        repeat (2) step();
        vec = 8'($urandom);
        pic_vec = vec;
        rst_n = 1'b1;
        t = cyc;
        s = t + 3;
        v = s + 2 * P + G;
        hs = v + 1;
        last = hs + G + 3;
        while (cyc < last) begin
            if (cyc == s + P + G) int_i = 1'b0;
            step();
            e = model_out(cyc, s, hs);
            vectors++;
            if ({inta_n, vec_valid, busy} !== e) begin
                miscompares++;
                $display("FAIL post_reset_wave cyc=%0d got=%b expected=%b", cyc,
                         {inta_n, vec_valid, busy}, e);
            end
            if (cyc < v || cyc == v) begin
                vectors++;
                if (vec_o !== ((cyc < v) ? 8'h00 : vec)) begin
                    miscompares++;
                    $display("FAIL post_reset_vec cyc=%0d got=%h expected=%h", cyc, vec_o,
                             (cyc < v) ? 8'h00 : vec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gating();
        test_back_to_back();
        test_reset_mid_p2();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- CPU-side interrupt acknowledge engine, directly downstream of the 8259-style PIC.
- Consumes the PIC INT output and drives the PIC INTA input with the two-pulse acknowledge protocol.
- Captures the vector byte the PIC places on the data bus during the second pulse.
- Hands the vector to the core over a valid/ready handshake.

Parameters:
- PULSE_W, 2: cycles each INTA pulse is held low (>=1).
- GAP_W, 2: cycles INTA is held high between pulse 1 and pulse 2, and in the recovery window after a vector is consumed (>=1).
- CNT_W, 4: width of the internal cycle counter; must hold max(PULSE_W, GAP_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- int_i  in  1  PIC INT output, asynchronous to clk, active high.
- ie  in  1  core interrupt-enable; new sequences start only when high.
- d_i  in  8  data bus as driven by the PIC during acknowledge.
- inta_n  out  1  acknowledge strobe to the PIC, active low.
- vec_o  out  8  captured interrupt vector.
- vec_valid  out  1  vec_o holds an unconsumed vector.
- vec_ready  in  1  core accepts the vector.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: inta_n=1, vec_o=0, vec_valid=0, busy=0.
  - State: IDLE, counter=0, synchronizer flops=0.
- int_i passes through a 2-flop synchronizer; int_s is the second flop. int_s lags int_i by 2 cycles.
- States: IDLE, P1, GAP, P2, HOLD, RECOVER. Each counted state loads its counter on entry and runs exactly its parameter width in cycles.
- IDLE:
  - If int_s=1 and ie=1, go to P1. Otherwise stay.
- P1:
  - inta_n=0 for PULSE_W cycles, then go to GAP.
  - The sequence is committed at P1 entry. It completes even if int_s or ie drops later.
- GAP:
  - inta_n=1 for GAP_W cycles, then go to P2.
- P2:
  - inta_n=0 for PULSE_W cycles.
  - On the clock edge ending the last P2 cycle, latch vec_o<=d_i, set vec_valid=1 and inta_n=1, and go to HOLD.
- HOLD:
  - inta_n=1. vec_o and vec_valid stay stable until the handshake.
  - The handshake is vec_valid&vec_ready at a clock edge.
  - On handshake: vec_valid<=0 and go to RECOVER. vec_o keeps its last value.
  - vec_ready while vec_valid=0 has no effect.
- RECOVER:
  - inta_n=1 for GAP_W cycles, then go to IDLE.
  - This window absorbs synchronizer latency so a stale int_s from the serviced request cannot trigger a back-to-back sequence.
  - After RECOVER, an int_s still high is treated as a new pending request.
- Total latency:
  - From the int_s rise seen in IDLE to vec_valid=1 is 2*PULSE_W+GAP_W+1 cycles (7 with defaults).
  - Add 2 cycles from int_i to int_s.
- ie only gates the IDLE->P1 transition. ie falling mid-sequence has no effect.
- int_i pulse shorter than 1 cycle: may be missed. int_i is level-type from the PIC, so this is not an error.
- Reset asserted mid-pulse: inta_n returns to 1 asynchronously, and any partially captured vector is discarded.
- The counter never wraps. It loads the parameter value on state entry and decrements to 1 before the transition.
- inta_n is registered, so it is glitch-free.

Test Plan:
- Reset idle: hold rst_n=0, toggle int_i -> inta_n=1, vec_valid=0, busy=0 throughout. Release -> no pulses while int_i=0.
- Basic acknowledge (defaults), ie=1:
  - Stimulus: raise int_i; model the PIC driving d_i=8'hAD during the second low pulse; vec_ready=1.
  - Response: exactly two inta_n low pulses of 2 cycles, separated by 2 high cycles; vec_o=8'hAD; vec_valid for 1 cycle; busy drops 2 cycles after the handshake.
- Backpressure: vec_ready=0 for 10 cycles after capture -> vec_valid stays 1, vec_o stable at 8'hAD, no further INTA pulses; raise vec_ready -> handshake completes, then RECOVER.
- Gating:
  - ie=0 with int_i=1 -> no pulses; set ie=1 -> sequence starts 1 cycle later.
  - Drop ie during GAP -> P2 still occurs and the vector is captured.
- Back-to-back: keep int_i=1 across two services with d_i=8'h75, then 8'h76 -> two full sequences, each vector delivered once, at least GAP_W high cycles of inta_n between them.
- Reset mid-P2: assert rst_n=0 while inta_n=0 -> inta_n=1 in the same cycle, vec_valid=0. After release with int_i=1, a fresh full sequence runs.
